uart_tx_port: RTL and testbench

//  Memory-mapped UART transmitter on the processor data bus, alongside DataMemory.

---
 rtl/uart_tx_port_pkg.sv | 35 +++
 rtl/uart_tx_port_fifo.sv | 68 ++++++
 rtl/uart_tx_port.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_port.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_port_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_port_pkg
//  Description : Shared definitions for the memory-mapped UART transmitter.
//                Contains the default register addresses, the status word bit
//                positions and the 2-bit transmit FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_port_pkg;

  // Default bus addresses of the two UART registers
  localparam logic [31:0] TX_ADDR_DEFAULT     = 32'h1001_0024;
  localparam logic [31:0] STATUS_ADDR_DEFAULT = 32'h1001_0028;

  // Status word bit positions
  localparam int STAT_FULL     = 0;
  localparam int STAT_BUSY     = 1;
  localparam int STAT_OVERFLOW = 2;
  localparam int STAT_EMPTY    = 3;
  localparam int STAT_CNT_LSB  = 4;
  localparam int STAT_CNT_MSB  = 7;

  // Bit in a STATUS_ADDR store that clears the sticky overflow flag
  localparam int CLR_OVERFLOW_BIT = 2;

  // Transmit FSM states
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_port_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tx_fifo
//  Description : Synchronous FIFO holding bytes waiting for transmission.
//                A push is accepted only when the FIFO is not full before the
//                edge (a pop in the same cycle does not make room); a pop is
//                honoured only when not empty. Pointers wrap modulo DEPTH.
//  Ports       : clk, reset (async, active-high)
//                push/din   - write request and data
//                pop/dout   - read request and head-of-queue data
//                full/empty - occupancy flags, count - entries held
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_fifo
  import uart_tx_port_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_port.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_port
//  Description : Memory-mapped 8N1 UART transmitter on the processor data
//                bus. Stores to TX_ADDR queue a byte; a store to STATUS_ADDR
//                with bit 2 set clears the sticky overflow flag; loads from
//                STATUS_ADDR return the status word.
//  Ports       : clk, reset (async, active-high)
//                Address/WriteData/MemWrite/MemRead - data bus
//                ReadData - status word on a STATUS_ADDR load, else 0
//                IOHit    - address decodes to one of the UART registers
//                TxD      - registered serial output, idle high
//                TxBusy   - frame in flight or bytes queued
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_port
  import uart_tx_port_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] TX_ADDR      = TX_ADDR_DEFAULT,
  parameter logic [31:0] STATUS_ADDR  = STATUS_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        IOHit,
  output logic        TxD,
  output logic        TxBusy
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  // Address decode
  logic tx_hit;
  logic status_hit;
  logic push_req;
  logic clear_req;

  // FIFO interface
  logic             fifo_pop;
  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Transmitter state
  tx_state_t         state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [7:0]        shift_reg;
  logic [2:0]        bit_idx;
  logic              txd_reg;
  logic              overflow;
  logic              baud_end;

  logic [31:0]       status_word;

  // Only the low byte of a TX store is transmitted
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^WriteData[31:8];

  assign tx_hit     = (Address == TX_ADDR);
  assign status_hit = (Address == STATUS_ADDR);
  assign IOHit      = tx_hit || status_hit;
  assign push_req   = MemWrite && tx_hit;
  assign clear_req  = MemWrite && status_hit && WriteData[CLR_OVERFLOW_BIT];

  // IDLE takes the head byte whenever one is waiting before the edge
  assign fifo_pop = (state == TX_IDLE) && !fifo_empty;
  assign baud_end = (baud_cnt == BAUD_LAST);

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .din   (WriteData[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sticky overflow: a dropped push wins over a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full) begin
      overflow <= 1'b1;
    end else if (clear_req) begin
      overflow <= 1'b0;
    end
  end

  // Transmit FSM. TxD is registered from the current state, so the line
  // level trails the state by one cycle; this gives the single idle-high
  // cycle between back-to-back frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= TX_IDLE;
      txd_reg   <= 1'b1;
      baud_cnt  <= '0;
      shift_reg <= '0;
      bit_idx   <= '0;
    end else begin
      case (state)
        TX_IDLE: begin
          txd_reg  <= 1'b1;
          baud_cnt <= '0;
          if (!fifo_empty) begin
            shift_reg <= fifo_dout;
            bit_idx   <= '0;
            state     <= TX_START;
          end
        end
        TX_START: begin
          txd_reg <= 1'b0;
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= TX_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          txd_reg <= shift_reg[0];
          if (baud_end) begin
            baud_cnt  <= '0;
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_idx   <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= TX_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          txd_reg <= 1'b1;
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= TX_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          txd_reg <= 1'b1;
          state   <= TX_IDLE;
        end
      endcase
    end
  end

  assign TxD    = txd_reg;
  assign TxBusy = (state != TX_IDLE) || !fifo_empty;

  always_comb begin
    status_word                             = '0;
    status_word[STAT_FULL]                  = fifo_full;
    status_word[STAT_BUSY]                  = TxBusy;
    status_word[STAT_OVERFLOW]              = overflow;
    status_word[STAT_EMPTY]                 = fifo_empty;
    status_word[STAT_CNT_MSB:STAT_CNT_LSB]  = 4'(fifo_count);
  end

  assign ReadData = (MemRead && status_hit) ? status_word : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_port.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_tx_port
//  Description : Self-checking bench for uart_tx_port (CLKS_PER_BIT=4,
//                FIFO_DEPTH=4). Expected bytes are queued as stores are made
//                and popped when the serial monitor completes a frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_port;

  localparam int          CPB   = 4;
  localparam int          FRAME = 10 * CPB;
  localparam int          GAP   = FRAME + 1;
  localparam logic [31:0] TXA   = 32'h1001_0024;
  localparam logic [31:0] STA   = 32'h1001_0028;
  localparam logic [31:0] RAMA  = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        IOHit;
  logic        TxD;
  logic        TxBusy;

  int errors = 0;
  int checks = 0;
  int frames = 0;
  int cyc    = 0;

  logic [7:0] exp_q[$];

  // Serial monitor state
  bit         mon_active = 0;
  int         mon_cnt;
  int         mon_bad;
  int         last_start = -1000;
  logic [9:0] mon_lvl;
  logic [7:0] mon_rx;
  logic [7:0] mon_exp;

  always #5 clk = ~clk;

  uart_tx_port #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4),
    .TX_ADDR      (TXA),
    .STATUS_ADDR  (STA)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .ReadData  (ReadData),
    .IOHit     (IOHit),
    .TxD       (TxD),
    .TxBusy    (TxBusy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one store for one rising edge; call at a falling edge
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    Address   = a;
    WriteData = d;
    MemWrite  = 1'b1;
    MemRead   = 1'b0;
    @(negedge clk);
    MemWrite  = 1'b0;
    Address   = 32'h0;
    WriteData = 32'h0;
  endtask

  task automatic send(input logic [7:0] b, input bit accepted);
    if (accepted) exp_q.push_back(b);
    store(TXA, {24'($urandom), b});
  endtask

  task automatic read_status(input string tag, input logic [31:0] exp);
    Address = STA;
    MemRead = 1'b1;
    #1;
    check(tag, ReadData, exp);
    check({tag, "_iohit"}, {31'b0, IOHit}, 32'h1);
    MemRead = 1'b0;
    Address = 32'h0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int k = 0;
    while ((TxBusy !== 1'b0 || mon_active) && k < bound) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_idle"}, {31'b0, TxBusy}, 32'h0);
    check({tag, "_drained"}, exp_q.size(), 0);
    repeat (2 * GAP) @(negedge clk);
  endtask

  // Serial monitor: every cycle of a frame must match the expected level
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset === 1'b1) begin
        mon_active = 0;
        last_start = -1000;
      end else begin
        if (!mon_active && TxD === 1'b0) begin
          mon_active = 1;
          mon_cnt    = 0;
          mon_bad    = 0;
          mon_rx     = 8'h00;
          check("frame_expected", {31'b0, exp_q.size() > 0}, 32'h1);
          mon_exp    = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
          mon_lvl    = {1'b1, mon_exp, 1'b0};
          if (cyc - last_start < 2 * GAP) check("frame_gap", cyc - last_start, GAP);
          last_start = cyc;
        end
        if (mon_active) begin
          if (TxD !== mon_lvl[mon_cnt / CPB]) mon_bad++;
          if ((mon_cnt % CPB) == 2 && mon_cnt / CPB >= 1 && mon_cnt / CPB <= 8)
            mon_rx[mon_cnt / CPB - 1] = TxD;
          if (mon_cnt == FRAME - 1) begin
            check("frame_levels", mon_bad, 0);
            check("rx_byte", {24'h0, mon_rx}, {24'h0, mon_exp});
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            frames++;
            mon_active = 0;
          end
          mon_cnt++;
        end
      end
    end
  end

  initial begin
    int k;
    reset     = 1'b1;
    Address   = 32'h0;
    WriteData = 32'h0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_txd", {31'b0, TxD}, 32'h1);
    check("reset_busy", {31'b0, TxBusy}, 32'h0);
    read_status("reset_status", 32'h0000_0008);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single byte, latency and frame length
    send(8'hA5, 1);
    @(negedge clk);
    check("lat_n1_txd", {31'b0, TxD}, 32'h1);
    check("lat_n1_busy", {31'b0, TxBusy}, 32'h1);
    @(negedge clk);
    check("lat_n2_txd", {31'b0, TxD}, 32'h0);
    k = 2;
    while (TxBusy === 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("busy_len", k, GAP);
    wait_idle("single", 100);

    // Back-to-back stores
    send(8'h55, 1);
    send(8'h0F, 1);
    send(8'hFF, 1);
    read_status("b2b_status", 32'h0000_0022);
    wait_idle("b2b", 400);

    // Overflow: first byte popped, four queued, sixth dropped
    send(8'h11, 1);
    send(8'h22, 1);
    send(8'h33, 1);
    send(8'h44, 1);
    send(8'h5A, 1);
    send(8'h66, 0);
    read_status("ovf_status", 32'h0000_0047);
    store(STA, 32'hFFFF_FFFB);
    read_status("ovf_keep", 32'h0000_0047);
    store(STA, 32'h0000_0004);
    read_status("ovf_clear", 32'h0000_0043);
    wait_idle("ovf", 600);

    // Decode
    Address = RAMA;
    MemRead = 1'b1;
    #1;
    check("ram_iohit", {31'b0, IOHit}, 32'h0);
    check("ram_rdata", ReadData, 32'h0);
    Address = TXA;
    #1;
    check("txa_iohit", {31'b0, IOHit}, 32'h1);
    check("txa_rdata", ReadData, 32'h0);
    MemRead = 1'b0;
    Address = 32'h0;
    @(negedge clk);
    store(RAMA, 32'h0000_00AB);
    read_status("ram_store_status", 32'h0000_0008);
    repeat (5) @(negedge clk);
    check("ram_store_txd", {31'b0, TxD}, 32'h1);
    check("ram_store_busy", {31'b0, TxBusy}, 32'h0);

    // Push coinciding with the IDLE pop at count=2
    send(8'hC1, 1);
    send(8'hC2, 1);
    send(8'hC3, 1);
    repeat (GAP - 2) @(negedge clk);
    read_status("pp_before", 32'h0000_0022);
    send(8'hC4, 1);
    read_status("pp_after", 32'h0000_0022);
    wait_idle("pp", 400);

    // Reset mid-DATA aborts the frame and discards queued bytes
    send(8'h3C, 1);
    send(8'h96, 1);
    repeat (15) @(negedge clk);
    check("rst_pre_busy", {31'b0, TxBusy}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_txd", {31'b0, TxD}, 32'h1);
    check("rst_busy", {31'b0, TxBusy}, 32'h0);
    read_status("rst_status", 32'h0000_0008);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    repeat (60) @(negedge clk);
    check("post_rst_txd", {31'b0, TxD}, 32'h1);
    check("post_rst_busy", {31'b0, TxBusy}, 32'h0);

    check("frame_total", frames, 13);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
